mem_st_responder: RTL and testbench

MEM_ST_RESPONDER -- requirements
Module: mem_st_responder

---
 rtl/mem_st_pkg.sv | 24 ++
 rtl/mem_st_resp_fifo.sv | 77 +++++++
 rtl/mem_st_responder.sv | 115 +++++++++++
 tb/tb_mem_st_responder.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_st_pkg.sv
// Shared types and parameter limits for the memory responder and its response buffer.
package mem_st_pkg;

  localparam int RESP_LATENCY_MIN    = 1;
  localparam int RESP_LATENCY_MAX    = 4;
  localparam int MAX_OUTSTANDING_MIN = 1;
  localparam int MAX_OUTSTANDING_MAX = 8;
  // Widest data path the response entry can carry; narrower instances zero-fill the top.
  localparam int RESP_DATA_MAX       = 128;
  localparam int AGE_W               = 2;

  typedef logic [AGE_W-1:0] age_t;

  typedef struct packed {
    logic [RESP_DATA_MAX-1:0] rdata;
    logic                     rerr;
    age_t                     age;
  } resp_entry_t;

  function automatic age_t age_limit(input int resp_latency);
    return age_t'(resp_latency - 1);
  endfunction

endpackage

// File: rtl/mem_st_resp_fifo.sv
// In-order response buffer; every stored entry ages each cycle and saturates at the latency limit.
module mem_st_resp_fifo
  import mem_st_pkg::*;
#(
  parameter  int ENTRIES      = 4,
  parameter  int RESP_LATENCY = 2,
  localparam int PTR_W        = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int CNT_W        = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  resp_entry_t      push_entry,
  input  logic             pop,
  output resp_entry_t      head_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam age_t AGE_LAST = age_limit(RESP_LATENCY);

  resp_entry_t      entries_reg [ENTRIES];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (count_reg == CNT_W'(ENTRIES));
  assign empty      = (count_reg == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign count      = count_reg;
  assign head_entry = entries_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Idle slots keep ageing too; a push always restarts its slot from the pushed age.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        entries_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (entries_reg[i].age != AGE_LAST) begin
          entries_reg[i].age <= entries_reg[i].age + age_t'(1);
        end
      end
      if (do_push) begin
        entries_reg[wr_ptr_reg] <= push_entry;
        wr_ptr_reg              <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mem_st_responder.sv
// Memory-backed request/response target with byte-enabled writes, fixed minimum latency
// and bounded outstanding responses.
module mem_st_responder
  import mem_st_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 256,
  parameter int RESP_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    stall_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rerr_o
);

  localparam int                  BE_W      = DATA_WIDTH / 8;
  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam age_t                AGE_LAST  = age_limit(RESP_LATENCY);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  generate
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0 || DATA_WIDTH > RESP_DATA_MAX) begin : g_bad_data_width
      $error("mem_st_responder: DATA_WIDTH must be a multiple of 8 in 8..%0d", RESP_DATA_MAX);
    end
    if (ADDR_WIDTH < 1 || DEPTH < 1 || (ADDR_WIDTH < 31 && DEPTH > (1 << ADDR_WIDTH))) begin : g_bad_depth
      $error("mem_st_responder: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if (RESP_LATENCY < RESP_LATENCY_MIN || RESP_LATENCY > RESP_LATENCY_MAX) begin : g_bad_latency
      $error("mem_st_responder: RESP_LATENCY out of range");
    end
    if (MAX_OUTSTANDING < MAX_OUTSTANDING_MIN || MAX_OUTSTANDING > MAX_OUTSTANDING_MAX) begin : g_bad_outstanding
      $error("mem_st_responder: MAX_OUTSTANDING out of range");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] be_mask;
  logic                  in_range;
  logic                  accept;
  logic                  pop;
  resp_entry_t           push_entry;
  resp_entry_t           head_entry;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  unused_fifo_bits;

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_mask
      assign be_mask[8*gi +: 8] = {8{be_i[gi]}};
    end
  endgenerate

  assign mem_idx  = addr_i[IDX_W-1:0];
  assign in_range = ({1'b0, addr_i} < DEPTH_EXT);

  // Grant depends only on registered occupancy, so a pop frees a slot one cycle later.
  assign gnt_o  = reset_n & req_i & ~stall_i & (fifo_count < CNT_W'(MAX_OUTSTANDING));
  assign accept = req_i & gnt_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (accept && we_i && in_range) begin
      mem_reg[mem_idx] <= (mem_reg[mem_idx] & ~be_mask) | (wdata_i & be_mask);
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.rerr = ~in_range;
    if (in_range && !we_i) begin
      push_entry.rdata = RESP_DATA_MAX'(mem_reg[mem_idx]);
    end
  end

  mem_st_resp_fifo #(
    .ENTRIES      (MAX_OUTSTANDING),
    .RESP_LATENCY (RESP_LATENCY)
  ) u_resp_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign rvalid_o = ~fifo_empty & (head_entry.age == AGE_LAST);
  assign pop      = rvalid_o & rready_i;
  assign rdata_o  = rvalid_o ? head_entry.rdata[DATA_WIDTH-1:0] : '0;
  assign rerr_o   = rvalid_o & head_entry.rerr;

  // Zero-filled upper data bits and the full flag are intentionally not consumed.
  assign unused_fifo_bits = ^{fifo_full, head_entry};

endmodule

// File: tb/tb_mem_st_responder.sv
// Directed bench for mem_st_responder: latency, byte enables, range errors, stall,
// backpressure and mid-operation reset.
module tb_mem_st_responder;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int MAXO  = 4;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b1;
  logic          req_i    = 1'b0;
  logic          we_i     = 1'b0;
  logic          stall_i  = 1'b0;
  logic          rready_i = 1'b1;
  logic [AW-1:0] addr_i   = '0;
  logic [3:0]    be_i     = '0;
  logic [DW-1:0] wdata_i  = '0;
  logic          gnt_o;
  logic          rvalid_o;
  logic          rerr_o;
  logic [DW-1:0] rdata_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_st_responder #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .RESP_LATENCY    (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .stall_i  (stall_i),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .rerr_o   (rerr_o)
  );

  task automatic drive(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [3:0] be, input logic [DW-1:0] wdata);
    req_i   = req;
    we_i    = we;
    addr_i  = addr;
    be_i    = be;
    wdata_i = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  task automatic test_reset();
    stall_i  = 1'b0;
    rready_i = 1'b1;
    drive(1'b1, 1'b0, 9'h010, 4'h0, '0);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== '0 || rerr_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs gnt=%b rvalid=%b rdata=%h rerr=%b required all 0",
               gnt_o, rvalid_o, rdata_o, rerr_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release gnt=%b rvalid=%b required gnt=1 rvalid=0", gnt_o, rvalid_o);
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp_d [2];
    exp_d[0] = 32'h0;
    exp_d[1] = 32'hDEADBEEF;
    rready_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0)      drive(1'b1, 1'b1, 9'h010, 4'hF, 32'hDEADBEEF);
      else if (j == 1) drive(1'b1, 1'b0, 9'h010, 4'h0, '0);
      else             idle();
      #1;
      if (j < 2) begin
        checks++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
          failures++;
          $display("FAIL wr_rd_issue cycle=%0d gnt=%b rvalid=%b required gnt=1 rvalid=0", j, gnt_o, rvalid_o);
        end
      end else if (j < 4) begin
        $display("txn wr_rd resp%0d rvalid=%b rdata=%h rerr=%b", j - 2, rvalid_o, rdata_o, rerr_o);
        checks++;
        if (rvalid_o !== 1'b1 || rerr_o !== 1'b0 || rdata_o !== exp_d[j-2]) begin
          failures++;
          $display("FAIL wr_rd_resp%0d rvalid=%b rdata=%h rerr=%b required 1 %h 0",
                   j - 2, rvalid_o, rdata_o, rerr_o, exp_d[j-2]);
        end
      end else begin
        checks++;
        if (rvalid_o !== 1'b0) begin
          failures++;
          $display("FAIL wr_rd_drain rvalid=%b required 0", rvalid_o);
        end
      end
    end
  endtask

  task automatic test_byte_enables();
    logic          w     [3];
    logic [3:0]    b     [3];
    logic [DW-1:0] d     [3];
    logic [DW-1:0] exp_d [3];
    w[0] = 1'b1; b[0] = 4'hF; d[0] = 32'hFFFFFFFF; exp_d[0] = 32'h0;
    w[1] = 1'b1; b[1] = 4'h5; d[1] = 32'h00000000; exp_d[1] = 32'h0;
    w[2] = 1'b0; b[2] = 4'h0; d[2] = 32'h00000000; exp_d[2] = 32'hFF00FF00;
    rready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j < 3) drive(1'b1, w[j], 9'h003, b[j], d[j]);
      else       idle();
      #1;
      if (j < 3) begin
        checks++;
        if (gnt_o !== 1'b1) begin
          failures++;
          $display("FAIL be_gnt cycle=%0d gnt=%b required 1", j, gnt_o);
        end
      end
      if (j >= 2 && j < 5) begin
        $display("txn be resp%0d rvalid=%b rdata=%h rerr=%b", j - 2, rvalid_o, rdata_o, rerr_o);
        checks++;
        if (rvalid_o !== 1'b1 || rerr_o !== 1'b0 || rdata_o !== exp_d[j-2]) begin
          failures++;
          $display("FAIL be_resp%0d rvalid=%b rdata=%h rerr=%b required 1 %h 0",
                   j - 2, rvalid_o, rdata_o, rerr_o, exp_d[j-2]);
        end
      end
      if (j == 5) begin
        checks++;
        if (rvalid_o !== 1'b0) begin
          failures++;
          $display("FAIL be_drain rvalid=%b required 0", rvalid_o);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic          w   [3];
    logic [AW-1:0] a   [3];
    logic          e   [3];
    w[0] = 1'b1; a[0] = 9'h100; e[0] = 1'b1;
    w[1] = 1'b0; a[1] = 9'h100; e[1] = 1'b1;
    w[2] = 1'b0; a[2] = 9'h000; e[2] = 1'b0;
    rready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j < 3) drive(1'b1, w[j], a[j], 4'hF, 32'hFFFFFFFF);
      else       idle();
      #1;
      if (j < 3) begin
        checks++;
        if (gnt_o !== 1'b1) begin
          failures++;
          $display("FAIL oor_gnt cycle=%0d gnt=%b required 1", j, gnt_o);
        end
      end
      if (j >= 2 && j < 5) begin
        $display("txn oor resp%0d rvalid=%b rdata=%h rerr=%b", j - 2, rvalid_o, rdata_o, rerr_o);
        checks++;
        if (rvalid_o !== 1'b1 || rerr_o !== e[j-2] || rdata_o !== 32'h0) begin
          failures++;
          $display("FAIL oor_resp%0d rvalid=%b rdata=%h rerr=%b required 1 00000000 %b",
                   j - 2, rvalid_o, rdata_o, rerr_o, e[j-2]);
        end
      end
    end
  endtask

  task automatic test_stall();
    rready_i = 1'b1;
    stall_i  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 9'h008, 4'hF, 32'h55AA55AA);
      #1;
      checks++;
      if (gnt_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_gnt cycle=%0d gnt=%b required 0", j, gnt_o);
      end
    end
    @(negedge clk);
    stall_i = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 1'b1 || rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_release gnt=%b rvalid=%b required gnt=1 rvalid=0", gnt_o, rvalid_o);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 9'h008, 4'h0, '0);
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_read_gnt gnt=%b required 1", gnt_o);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'h0 || rerr_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_wr_resp rvalid=%b rdata=%h rerr=%b required 1 00000000 0", rvalid_o, rdata_o, rerr_o);
    end
    @(negedge clk);
    #1;
    $display("txn stall read rvalid=%b rdata=%h rerr=%b", rvalid_o, rdata_o, rerr_o);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'h55AA55AA || rerr_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_rd_resp rvalid=%b rdata=%h rerr=%b required 1 55aa55aa 0", rvalid_o, rdata_o, rerr_o);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] rd_a  [5];
    logic [DW-1:0] exp_d [5];
    logic [DW-1:0] pre_d [3];
    int            k;
    rd_a[0] = 9'h010; exp_d[0] = 32'hDEADBEEF;
    rd_a[1] = 9'h003; exp_d[1] = 32'hFF00FF00;
    rd_a[2] = 9'h005; exp_d[2] = 32'h12345678;
    rd_a[3] = 9'h006; exp_d[3] = 32'hCAFEF00D;
    rd_a[4] = 9'h007; exp_d[4] = 32'h0BADC0DE;
    pre_d[0] = 32'h12345678; pre_d[1] = 32'hCAFEF00D; pre_d[2] = 32'h0BADC0DE;
    rready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, rd_a[j+2], 4'hF, pre_d[j]);
      #1;
      checks++;
      if (gnt_o !== 1'b1) begin
        failures++;
        $display("FAIL bb_prefill_gnt cycle=%0d gnt=%b required 1", j, gnt_o);
      end
    end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);

    rready_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, rd_a[j], 4'h0, '0);
      #1;
      checks++;
      if (gnt_o !== 1'b1) begin
        failures++;
        $display("FAIL bb_gnt cycle=%0d gnt=%b required 1", j, gnt_o);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b0, rd_a[4], 4'h0, '0);
    #1;
    checks++;
    if (gnt_o !== 1'b0 || rvalid_o !== 1'b1 || rdata_o !== exp_d[0]) begin
      failures++;
      $display("FAIL bb_full gnt=%b rvalid=%b rdata=%h required gnt=0 rvalid=1 rdata=%h",
               gnt_o, rvalid_o, rdata_o, exp_d[0]);
    end
    @(negedge clk);
    rready_i = 1'b1;
    #1;
    $display("txn bb resp0 rvalid=%b rdata=%h rerr=%b", rvalid_o, rdata_o, rerr_o);
    checks++;
    if (gnt_o !== 1'b0 || rvalid_o !== 1'b1 || rdata_o !== exp_d[0]) begin
      failures++;
      $display("FAIL bb_hold gnt=%b rvalid=%b rdata=%h required gnt=0 rvalid=1 rdata=%h",
               gnt_o, rvalid_o, rdata_o, exp_d[0]);
    end
    k = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) idle();
      #1;
      if (c == 0) begin
        checks++;
        if (gnt_o !== 1'b1) begin
          failures++;
          $display("FAIL bb_regrant gnt=%b required 1", gnt_o);
        end
      end
      if (rvalid_o === 1'b1) begin
        $display("txn bb resp%0d rdata=%h rerr=%b", k, rdata_o, rerr_o);
        checks++;
        if (k >= 5) begin
          failures++;
          $display("FAIL bb_extra_resp rdata=%h required no response", rdata_o);
        end else if (rdata_o !== exp_d[k] || rerr_o !== 1'b0) begin
          failures++;
          $display("FAIL bb_order resp%0d rdata=%h rerr=%b required %h 0", k, rdata_o, rerr_o, exp_d[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 5) begin
      failures++;
      $display("FAIL bb_count responses=%0d required 5", k);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] wa [3];
    logic [AW-1:0] ra [4];
    int            seen;
    wa[0] = 9'h010; wa[1] = 9'h005; wa[2] = 9'h003;
    ra[0] = 9'h010; ra[1] = 9'h005; ra[2] = 9'h003; ra[3] = 9'h008;
    rready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, wa[j], 4'hF, 32'hA5A5A5A5);
      #1;
      checks++;
      if (gnt_o !== 1'b1) begin
        failures++;
        $display("FAIL mid_gnt cycle=%0d gnt=%b required 1", j, gnt_o);
      end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rvalid_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_pending rvalid=%b required 1", rvalid_o);
    end
    #1;
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 9'h010, 4'h0, '0);
    #1;
    checks++;
    if (rvalid_o !== 1'b0 || gnt_o !== 1'b0 || rdata_o !== '0 || rerr_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs rvalid=%b gnt=%b rdata=%h rerr=%b required all 0",
               rvalid_o, gnt_o, rdata_o, rerr_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    rready_i = 1'b1;
    idle();
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (rvalid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_stale rvalid_cycles=%0d required 0", seen);
    end
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j < 4) drive(1'b1, 1'b0, ra[j], 4'h0, '0);
      else       idle();
      #1;
      if (j >= 2 && j < 6) begin
        $display("txn mid read%0d rvalid=%b rdata=%h rerr=%b", j - 2, rvalid_o, rdata_o, rerr_o);
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h0 || rerr_o !== 1'b0) begin
          failures++;
          $display("FAIL mid_cleared%0d rvalid=%b rdata=%h rerr=%b required 1 00000000 0",
                   j - 2, rvalid_o, rdata_o, rerr_o);
        end
      end
      if (j == 6) begin
        checks++;
        if (rvalid_o !== 1'b0) begin
          failures++;
          $display("FAIL mid_drain rvalid=%b required 0", rvalid_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_out_of_range();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
